// File: rtl/ro_measure_ctrl.sv
// rtl/ro_measure_ctrl.sv - ring oscillator measurement sequencer
// Enables one ring at a time, settles it, counts synchronised rising edges over a clk window.
module ro_measure_ctrl #(
    parameter int N_RO        = 8,
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = $clog2(N_RO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] ro_sel,
    input  logic [WIN_W-1:0] win_len,
    input  logic [N_RO-1:0]  ro_in,
    output logic [N_RO-1:0]  ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             sel_err
);

    localparam int SMALL_W = $clog2(SETTLE_CYC + SYNC_STAGES + 2);
    localparam int TMR_W   = (WIN_W > SMALL_W) ? WIN_W : SMALL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_STOP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               serr_q, serr_d;
    logic [N_RO-1:0]    ro_en_q, ro_en_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               edge_q;
    logic               ro_mux;
    logic               rise;

    // Ring mux sits ahead of the synchroniser so only one async net is sampled.
    always_comb begin
        ro_mux = 1'b0;
        for (int i = 0; i < N_RO; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ro_mux = ro_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ro_mux};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            win_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
            ro_en_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            win_q   <= win_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
            ro_en_q <= ro_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        win_d   = win_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        serr_d  = serr_q;
        ro_en_d = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d  = ro_sel;
                    win_d  = win_len;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    serr_d = 1'b0;
                    if (32'(ro_sel) >= 32'(N_RO)) begin
                        serr_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (win_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        tmr_d   = TMR_W'(SETTLE_CYC - 1);
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(win_q) - TMR_W'(1);
                    state_d = S_COUNT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_COUNT: begin
                if (tmr_q == '0) begin
                    tmr_d   = TMR_W'(SYNC_STAGES);
                    state_d = S_STOP;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_STOP: begin
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // STOP keeps counting so edges still in the synchroniser are not lost.
        if ((state_q == S_COUNT || state_q == S_STOP) && rise) begin
            if (cnt_q == {CNT_W{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Enable decoded from the next state and registered, so it never glitches.
        if (state_d == S_SETTLE || state_d == S_COUNT) begin
            for (int i = 0; i < N_RO; i++) begin
                if (sel_d == SEL_W'(i)) begin
                    ro_en_d[i] = 1'b1;
                end
            end
        end
    end

    assign ro_en    = ro_en_q;
    assign busy     = (state_q == S_SETTLE) || (state_q == S_COUNT) || (state_q == S_STOP);
    assign done     = (state_q == S_DONE);
    assign count    = cnt_q;
    assign overflow = ovf_q;
    assign sel_err  = serr_q;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb/tb_ro_measure_ctrl.sv - scoreboard bench for ro_measure_ctrl (16-bit and 4-bit count instances)
module tb_ro_measure_ctrl;

    localparam int SETTLE = 4;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ro_sel = '0;
    logic [15:0] win_len = '0;
    logic [7:0]  ro_in_a, ro_in_b, ro_en_a, ro_en_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b, serr_a, serr_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int cyc;
        int cnt;
        int tol;
        bit ov;
        bit se;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ro_measure_ctrl #(.N_RO(8), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE),
                      .SYNC_STAGES(SYNC), .SEL_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .ro_sel(ro_sel), .win_len(win_len),
        .ro_in(ro_in_a), .ro_en(ro_en_a), .busy(busy_a), .done(done_a),
        .count(count_a), .overflow(ovf_a), .sel_err(serr_a));

    ro_measure_ctrl #(.N_RO(8), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE),
                      .SYNC_STAGES(SYNC), .SEL_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .ro_sel(ro_sel), .win_len(win_len),
        .ro_in(ro_in_b), .ro_en(ro_en_b), .busy(busy_b), .done(done_b),
        .count(count_b), .overflow(ovf_b), .sel_err(serr_b));

    // Ring model: runs only while enabled, toggles every 2 clk (rise every 4 clk).
    logic [1:0] ph_a = '0;
    logic [1:0] ph_b = '0;
    always @(posedge clk) ph_a <= (ro_en_a == '0) ? 2'd0 : ph_a + 2'd1;
    always @(posedge clk) ph_b <= (ro_en_b == '0) ? 2'd0 : ph_b + 2'd1;
    assign ro_in_a = ro_en_a & {8{ph_a[1]}};
    assign ro_in_b = ro_en_b & {8{ph_b[1]}};

    task automatic check(input bit ok, input string nm, input int act, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input int sel, input int win, input int cmax, input int t0);
        exp_t e;
        int   edges;
        e.cyc = t0; e.cnt = 0; e.tol = 0; e.ov = 1'b0; e.se = 1'b0;
        if (sel >= 8) begin
            e.se = 1'b1;
        end else if (win != 0) begin
            e.cyc = t0 + SETTLE + win + SYNC + 1;
            edges = win / 4;
            if (edges + 1 <= cmax) begin
                e.cnt = edges;
                e.tol = 1;
            end else begin
                e.cnt = cmax;
                e.ov  = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic cmp(input string who, input exp_t e, input int cnt, input bit ov, input bit se);
        check(cyc == e.cyc, {who, "_done_cycle"}, cyc, e.cyc);
        check((cnt >= e.cnt - e.tol) && (cnt <= e.cnt + e.tol), {who, "_count"}, cnt, e.cnt);
        check(ov == e.ov, {who, "_overflow"}, int'(ov), int'(e.ov));
        check(se == e.se, {who, "_sel_err"}, int'(se), int'(e.se));
    endtask

    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (qa.size() == 0) check(1'b0, "a_unexpected_done", 1, 0);
            else cmp("a", qa.pop_front(), int'(count_a), ovf_a, serr_a);
        end
    end

    always @(negedge clk) begin
        if (rst_n && done_b) begin
            if (qb.size() == 0) check(1'b0, "b_unexpected_done", 1, 0);
            else cmp("b", qb.pop_front(), int'(count_b), ovf_b, serr_b);
        end
    end

    task automatic issue(input int sel, input int win);
        int t0;
        @(negedge clk);
        start   = 1'b1;
        ro_sel  = 4'(sel);
        win_len = 16'(win);
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        qa.push_back(mk(sel, win, 65535, t0));
        qb.push_back(mk(sel, win, 15, t0));
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 1000 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
        check(qa.size() == 0 && qb.size() == 0, "done_timeout", qa.size() + qb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [15:0] held;

        // Reset and idle
        repeat (3) @(negedge clk);
        check(ro_en_a == 8'h00 && ro_en_b == 8'h00, "reset_ro_en", int'(ro_en_a | ro_en_b), 0);
        check(!busy_a && !busy_b && !done_a && !done_b, "reset_busy_done",
              int'({busy_a, busy_b, done_a, done_b}), 0);
        check(count_a == 16'd0 && count_b == 4'd0, "reset_count", int'(count_a), 0);
        check(!ovf_a && !serr_a, "reset_flags", int'({ovf_a, serr_a}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check(ro_en_a == 8'h00 && !busy_a, "idle_no_activity", int'(ro_en_a), 0);

        // Nominal measurement on ring 3
        issue(3, 100);
        check(ro_en_a == 8'h08, "nominal_ro_en_settle", int'(ro_en_a), 8);
        check(busy_a == 1'b1, "nominal_busy", int'(busy_a), 1);
        repeat (50) @(posedge clk);
        #1;
        check(ro_en_a == 8'h08, "nominal_ro_en_count", int'(ro_en_a), 8);
        wait_idle();
        held = count_a;
        repeat (5) @(negedge clk);
        check(count_a == held && !busy_a, "count_held_after_done", int'(count_a), int'(held));

        // Saturation then a short window clears overflow
        issue(3, 200);
        wait_idle();
        issue(3, 8);
        wait_idle();

        // Bad select
        issue(9, 10);
        check(ro_en_a == 8'h00 && ro_en_b == 8'h00, "badsel_ro_en", int'(ro_en_a), 0);
        wait_idle();
        check(ro_en_a == 8'h00, "badsel_ro_en_after", int'(ro_en_a), 0);

        // Start during COUNT is ignored
        issue(3, 40);
        repeat (15) @(posedge clk);
        @(negedge clk);
        start   = 1'b1;
        ro_sel  = 4'd5;
        win_len = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check(ro_en_a == 8'h08, "ignored_start_ro_en", int'(ro_en_a), 8);
        wait_idle();
        repeat (10) @(posedge clk);

        // Zero window
        issue(2, 0);
        check(ro_en_a == 8'h00, "zero_win_ro_en", int'(ro_en_a), 0);
        wait_idle();

        // Reset in the middle of COUNT
        issue(1, 50);
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check(ro_en_a == 8'h00 && ro_en_b == 8'h00, "async_reset_ro_en", int'(ro_en_a), 0);
        check(!busy_a && count_a == 16'd0, "async_reset_state", int'(count_a), 0);
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1, 20);
        check(ro_en_a == 8'h02, "post_reset_ro_en", int'(ro_en_a), 2);
        wait_idle();

        check(qa.size() == 0 && qb.size() == 0, "scoreboard_empty", qa.size() + qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
